// File: rtl/dm_ctrl.sv
// dm_ctrl - data memory for the MEM stage of the pipelined CPU.
//   Word array with byte-lane merge on stores and signed/unsigned half/byte loads.
//   Requests are checked for alignment, range and legal op code.
//   The valid/ready request port returns a registered response one cycle after accept.
//   After every reset the array is swept to zero; busy is high and req_ready low while it runs.
//   Optional build macro: DM_TRACE_EN prints one trace line per committed store.
module dm_ctrl #(
  parameter int unsigned DEPTH     = 3072,
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_HS = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_BS = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  // Byte size of the array, widened so DEPTH*4 cannot wrap the compare.
  localparam logic [32:0] LIMIT    = {1'b0, 32'(DEPTH)} << 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_last;
  logic              clr_we;

  logic [31:0] mem [DEPTH];

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic              is_half;
  logic              is_byte;
  logic              misalign;
  logic              out_of_range;
  logic              illegal_op;
  logic              req_err;
  logic              accept;
  logic              st_commit;
  logic [31:0]       old_word;
  logic [31:0]       merged;

  logic              vld_p1;
  logic              err_p1;
  logic              ld_p1;
  logic [31:0]       rd_word_p1;
  logic [2:0]        op_p1;
  logic [1:0]        lane_p1;

  // Replace the lanes addressed by a store, keeping the rest of the old word.
  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] wd,
                                          input logic [2:0]  op,
                                          input logic [1:0]  lane);
    logic [31:0] r;
    r = old_w;
    case (op)
      OP_W: r = wd;
      OP_HS, OP_HU: begin
        if (lane[1]) r = {wd[15:0], old_w[15:0]};
        else         r = {old_w[31:16], wd[15:0]};
      end
      OP_BS, OP_BU: begin
        case (lane)
          2'd0:    r = {old_w[31:8], wd[7:0]};
          2'd1:    r = {old_w[31:16], wd[7:0], old_w[7:0]};
          2'd2:    r = {old_w[31:24], wd[7:0], old_w[15:0]};
          default: r = {wd[7:0], old_w[23:0]};
        endcase
      end
      default: r = old_w;
    endcase
    return r;
  endfunction

  // Pick the addressed half/byte of a loaded word and sign- or zero-extend it.
  function automatic logic [31:0] f_extend(input logic [31:0] w,
                                           input logic [2:0]  op,
                                           input logic [1:0]  lane);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = lane[1] ? w[31:16] : w[15:0];
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (op)
      OP_W:    r = w;
      OP_HS:   r = {{16{h[15]}}, h};
      OP_HU:   r = {16'h0000, h};
      OP_BS:   r = {{24{b[7]}}, b};
      OP_BU:   r = {24'h00_0000, b};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Request decode: offset into the array, word index and the three error checks.
  always_comb begin
    off          = req_addr - BASE_ADDR;
    idx          = off[ADDR_W+1:2];
    is_half      = (req_op == OP_HS) || (req_op == OP_HU);
    is_byte      = (req_op == OP_BS) || (req_op == OP_BU);
    misalign     = ((req_op == OP_W) && (off[1:0] != 2'b00)) || (is_half && off[0]);
    out_of_range = ({1'b0, off} >= LIMIT);
    illegal_op   = (req_op >= 3'd5);
    req_err      = misalign || out_of_range || illegal_op;
    accept       = req_valid && req_ready;
    st_commit    = accept && req_we && !req_err;
    old_word     = mem[idx];
    merged       = f_merge(old_word, req_wdata, req_op, off[1:0]);
  end

  // FSM state register; reset restarts the clear sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  // FSM next state: leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_last) state_nxt = S_IDLE;
      S_IDLE:  state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // FSM outputs: the request port is closed while the sweep runs.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    clr_we    = 1'b0;
    case (state)
      S_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign clr_last = (clr_ptr == LAST_IDX);

  // Clear pointer walks the array once per sweep and parks at zero afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          clr_ptr <= '0;
    else if (clr_we && !clr_last)        clr_ptr <= clr_ptr + 1'b1;
    else                                 clr_ptr <= '0;
  end

  // ---- stage p0 -> p1: array access at the accept edge ----
  // Response control: valid, error and "has load data" flags for the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      ld_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      err_p1 <= accept && req_err;
      ld_p1  <= accept && !req_we && !req_err;
    end
  end

  // Array write port (sweep or committed store) and registered read data.
  always_ff @(posedge clk) begin
    if (clr_we)         mem[clr_ptr] <= 32'h0000_0000;
    else if (st_commit) mem[idx]     <= merged;
    rd_word_p1 <= old_word;
    op_p1      <= req_op;
    lane_p1    <= off[1:0];
  end

  // ---- stage p1: response formatting ----
  // Load data is extended from the registered word; stores and errors return zero.
  always_comb begin
    rsp_valid = vld_p1;
    rsp_err   = err_p1;
    rsp_rdata = ld_p1 ? f_extend(rd_word_p1, op_p1, lane_p1) : 32'h0000_0000;
  end

`ifdef DM_TRACE_EN
  // Trace every committed store with its PC, word address and merged word.
  always_ff @(posedge clk) begin
    if (st_commit) $display("@%h: *%h <= %h", req_pc, {req_addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

  logic unused_lanes;
  assign unused_lanes = is_byte;

endmodule
